req_arbiter: RTL and testbench

- Responder end of the writer req/busy handshake. Serves N_WRITERS writers, each holding o_req plus o_data.
- Grants one writer at a time by dropping that writer's busy line for one cycle, and captures its data on that cycle.
- Forwards each captured word to a single downstream sink over a valid/ready interface.
- Sits between the writer instances and the shared resource (memory/UART) they contend for.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 56 +++++
 rtl/req_arbiter.sv | 117 +++++++++++
 tb/tb_req_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM encodings and index-width helper for req_arbiter.
// Used by req_arbiter and rr_pick.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        GNT  = 2'd1,
        SEND = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational writer selector for req_arbiter.
// Macro REQ_ARBITER_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    assign any = |req;

`ifdef REQ_ARBITER_FIXED_PRIO_EN

    logic unused_last;
    assign unused_last = ^last;

    // lowest asserted index wins; scan downward so the last hit is lowest
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

`else

    logic          found;
    logic [IW-1:0] cand;
    int            j;

    // search from last+1 upward with wrap; first asserted request wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        j     = 0;
        for (int i = 1; i <= N; i++) begin
            j    = (int'(last) + i) % N;
            cand = IW'(j);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: responder end of the writer req/busy handshake,
// forwarding one captured word at a time; see REQ_ARBITER_FIXED_PRIO_EN.
module req_arbiter
    import arb_pkg::*;
#(
    parameter int N_WRITERS = 4,
    parameter int DATA_W    = 8,
    localparam int IW = idx_w(N_WRITERS)
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [N_WRITERS-1:0]       i_req,
    input  logic [N_WRITERS*DATA_W-1:0] i_data,
    output logic [N_WRITERS-1:0]       o_busy,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    output logic [IW-1:0]              o_src,
    input  logic                       i_ready
);

    state_t                state_q, state_d;
    logic [N_WRITERS-1:0]  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [IW-1:0]         src_q, src_d;
    logic [IW-1:0]         last_q, last_d;
    logic [IW-1:0]         gnt_q, gnt_d;

    logic                  any_req;
    logic [IW-1:0]         pick;
    logic [DATA_W-1:0]     slice;

    rr_pick #(
        .N (N_WRITERS)
    ) u_pick (
        .req  (i_req),
        .last (last_q),
        .any  (any_req),
        .idx  (pick)
    );

    // data word of the writer currently holding the grant
    always_comb begin
        slice = i_data[gnt_q*DATA_W +: DATA_W];
    end

    // next-state and registered-output logic for the handshake FSM
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            ARB: begin
                busy_d = '1;
                if (any_req) begin
                    busy_d[pick] = 1'b0;
                    gnt_d        = pick;
                    state_d      = GNT;
                end
            end
            GNT: begin
                busy_d  = '1;
                state_d = ARB;
                if (i_req[gnt_q]) begin
                    data_d  = slice;
                    src_d   = gnt_q;
                    valid_d = 1'b1;
                    last_d  = gnt_q;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy_d = '1;
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ARB;
                end
            end
            default: begin
                busy_d  = '1;
                valid_d = 1'b0;
                state_d = ARB;
            end
        endcase
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ARB;
            busy_q  <= '1;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            last_q  <= IW'(N_WRITERS - 1);
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_src   = src_q;

endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed self-checking bench for req_arbiter
// (N_WRITERS=4, DATA_W=8).
module tb_req_arbiter;

    logic        i_clk;
    logic        i_reset_n;
    logic [3:0]  i_req;
    logic [31:0] i_data;
    logic [3:0]  o_busy;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [1:0]  o_src;
    logic        i_ready;

    int errors = 0;
    int checks = 0;

    req_arbiter #(
        .N_WRITERS (4),
        .DATA_W    (8)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     (i_req),
        .i_data    (i_data),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_src     (o_src),
        .i_ready   (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_reset_n = 1'b0;
        tick();
        tick();
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        i_req   = 4'b1111;
        i_ready = 1'b1;
        i_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        i_reset_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (o_busy !== 4'b1111 || o_valid !== 1'b0 || o_data !== 8'h00
                || o_src !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d busy=%b valid=%b data=%h src=%0d want 1111/0/00/0",
                         c, o_busy, o_valid, o_data, o_src);
            end
        end
        i_reset_n = 1'b1;
        tick();
        checks++;
        if (o_busy !== 4'b1110) begin
            errors++;
            $display("FAIL reset_first_grant busy=%b want 1110", o_busy);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_src !== 2'd0 || o_data !== 8'h11) begin
            errors++;
            $display("FAIL reset_first_word valid=%b src=%0d data=%h want 1/0/11",
                     o_valid, o_src, o_data);
        end
        i_req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_single();
        i_req   = 4'b0100;
        i_data  = {8'h00, 8'h05, 8'h00, 8'h00};
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_busy !== 4'b1011 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_grant busy=%b valid=%b want 1011/0", o_busy, o_valid);
        end
        tick();
        checks++;
        if (o_busy !== 4'b1111 || o_valid !== 1'b1 || o_data !== 8'h05
            || o_src !== 2'd2) begin
            errors++;
            $display("FAIL single_word busy=%b valid=%b data=%h src=%0d want 1111/1/05/2",
                     o_busy, o_valid, o_data, o_src);
        end
        i_req = 4'b0000;
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drop valid=%b want 0", o_valid);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_busy !== 4'b1111 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_idle cyc%0d busy=%b valid=%b want 1111/0",
                         c, o_busy, o_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_busy;
        logic [1:0] w;
        apply_reset();
        i_req   = 4'b1111;
        i_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        i_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            w = 2'(g % 4);
            exp_busy = 4'b1111;
            exp_busy[w] = 1'b0;
            tick();
            checks++;
            if (o_busy !== exp_busy || $countones(~o_busy) != 1) begin
                errors++;
                $display("FAIL rr_grant%0d busy=%b want %b", g, o_busy, exp_busy);
            end
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_src !== w || o_data !== 8'h10 + 8'(w)) begin
                errors++;
                $display("FAIL rr_word%0d valid=%b src=%0d data=%h want 1/%0d/%h",
                         g, o_valid, o_src, o_data, w, 8'h10 + 8'(w));
            end
            if (g == 4) i_req = 4'b0000;
            tick();
            checks++;
            if (o_valid !== 1'b0 || o_busy !== 4'b1111) begin
                errors++;
                $display("FAIL rr_arb%0d valid=%b busy=%b want 0/1111", g, o_valid, o_busy);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        i_req   = 4'b0010;
        i_data  = {8'h00, 8'h00, 8'hA5, 8'h3C};
        i_ready = 1'b0;
        tick();
        checks++;
        if (o_busy !== 4'b1101) begin
            errors++;
            $display("FAIL bp_grant busy=%b want 1101", o_busy);
        end
        tick();
        i_req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== 8'hA5 || o_src !== 2'd1
                || o_busy !== 4'b1111) begin
                errors++;
                $display("FAIL bp_hold cyc%0d valid=%b data=%h src=%0d busy=%b want 1/A5/1/1111",
                         c, o_valid, o_data, o_src, o_busy);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b1 || o_busy !== 4'b1111) begin
            errors++;
            $display("FAIL bp_hold_end valid=%b busy=%b want 1/1111", o_valid, o_busy);
        end
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 4'b1111) begin
            errors++;
            $display("FAIL bp_release valid=%b busy=%b want 0/1111", o_valid, o_busy);
        end
        tick();
        checks++;
        if (o_busy !== 4'b1110) begin
            errors++;
            $display("FAIL bp_next_grant busy=%b want 1110", o_busy);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_src !== 2'd0 || o_data !== 8'h3C) begin
            errors++;
            $display("FAIL bp_next_word valid=%b src=%0d data=%h want 1/0/3C",
                     o_valid, o_src, o_data);
        end
        i_req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_violation();
        i_ready = 1'b1;
        i_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        i_req   = 4'b0100;
        tick();
        tick();
        i_req = 4'b0000;
        tick();
        tick();
        i_req = 4'b1000;
        tick();
        checks++;
        if (o_busy !== 4'b0111) begin
            errors++;
            $display("FAIL viol_grant busy=%b want 0111", o_busy);
        end
        i_req = 4'b0000;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 4'b1111) begin
            errors++;
            $display("FAIL viol_nocapture valid=%b busy=%b want 0/1111", o_valid, o_busy);
        end
        i_req = 4'b1111;
        tick();
        checks++;
        if (o_busy !== 4'b0111) begin
            errors++;
            $display("FAIL viol_pointer busy=%b want 0111", o_busy);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_src !== 2'd3 || o_data !== 8'hD3) begin
            errors++;
            $display("FAIL viol_word valid=%b src=%0d data=%h want 1/3/D3",
                     o_valid, o_src, o_data);
        end
        i_req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_pair_pick();
        logic [1:0] exp_src;
        apply_reset();
        i_req   = 4'b1010;
        i_ready = 1'b1;
        i_data  = {8'h77, 8'h00, 8'h55, 8'h00};
        for (int g = 0; g < 4; g++) begin
`ifdef REQ_ARBITER_FIXED_PRIO_EN
            exp_src = 2'd1;
`else
            exp_src = (g % 2 == 0) ? 2'd1 : 2'd3;
`endif
            tick();
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_src !== exp_src) begin
                errors++;
                $display("FAIL pair_pick%0d valid=%b src=%0d want 1/%0d",
                         g, o_valid, o_src, exp_src);
            end
            if (g == 3) i_req = 4'b0000;
            tick();
        end
        tick();
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_req     = '0;
        i_data    = '0;
        i_ready   = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_violation();
        test_pair_pick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
